// File: rtl/regfile_param.sv
// Width/depth-configurable register file: two combinational read ports, one write port,
// optional hardwired-zero r0, optional write-to-read bypass, and a sequenced bulk clear.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              ctrl_clear,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } clearState_t;

  clearState_t       state;
  clearState_t       stateNext;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptrNext;
  logic              doneNext;
  logic              writeAccepted;
  logic              bypassLive;
  logic [WIDTH-1:0]  regs [DEPTH];

  // Writes are only honoured while idle, and never land in a hardwired-zero r0.
  assign writeAccepted = ctrl_writeEnable && (state == IDLE) &&
                         !((ZERO_REG != 0) && (ctrl_writeReg == '0));
  assign bypassLive    = (BYPASS != 0) && (state == IDLE) && ctrl_writeEnable;
  assign clear_busy    = (state == CLEAR);

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state      <= IDLE;
      ptr        <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= stateNext;
      ptr        <= ptrNext;
      clear_done <= doneNext;
    end
  end

  // Clear engine: walks ptr from FIRST up to the last register, one per cycle.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_clear) begin
          stateNext = CLEAR;
          ptrNext   = FIRST;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          ptrNext = ptr + ADDR_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[ptr] <= '0;
    end else if (writeAccepted) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Zero-register override has priority over the bypass path.
  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) begin
      data_readRegA = '0;
    end else if (bypassLive && (ctrl_writeReg == ctrl_readRegA)) begin
      data_readRegA = data_writeReg;
    end
  end

  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) begin
      data_readRegB = '0;
    end else if (bypassLive && (ctrl_writeReg == ctrl_readRegB)) begin
      data_readRegB = data_writeReg;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: two instances (zero-reg+bypass, plain) driven in
// lockstep, expected outputs from an array/queue reference model checked at negedge.
module tb_regfile_param;

  logic        clock;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        clr;
  logic [31:0] rA0, rB0, rA1, rB1;
  logic        busy0, done0, busy1, done1;

  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rA0), .data_readRegB(rB0), .ctrl_clear(clr),
    .clear_busy(busy0), .clear_done(done0)
  );

  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rA1), .data_readRegB(rB1), .ctrl_clear(clr),
    .clear_busy(busy1), .clear_done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a0, b0;
    logic        busy0, done0;
    logic [31:0] a1, b1;
    logic        busy1, done1;
  } expT;

  expT         expQ[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: cfg 0 has hardwired r0 and bypass, cfg 1 has neither.
  logic [31:0] mem [2][32];
  int          clrQ0[$];
  int          clrQ1[$];
  bit          doneM [2];

  function automatic int qSize(input int cfg);
    return (cfg == 0) ? clrQ0.size() : clrQ1.size();
  endfunction

  function automatic logic [31:0] expRead(input int cfg, input logic [4:0] addr);
    if (cfg == 0 && addr == 5'd0) return 32'd0;
    if (cfg == 0 && qSize(cfg) == 0 && we && wa == addr) return wd;
    return mem[cfg][addr];
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) mem[c][i] = 32'd0;
      doneM[c] = 1'b0;
    end
    clrQ0.delete();
    clrQ1.delete();
  endtask

  task automatic modelStep(input int cfg);
    int idx;
    if (qSize(cfg) > 0) begin
      if (cfg == 0) idx = clrQ0.pop_front();
      else          idx = clrQ1.pop_front();
      mem[cfg][idx] = 32'd0;
      doneM[cfg] = (qSize(cfg) == 0);
    end else begin
      doneM[cfg] = 1'b0;
      if (we && !(cfg == 0 && wa == 5'd0)) mem[cfg][wa] = wd;
      if (clr) begin
        for (int j = (cfg == 0) ? 1 : 0; j < 32; j++) begin
          if (cfg == 0) clrQ0.push_back(j);
          else          clrQ1.push_back(j);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wAddr,
                               input logic [31:0] wData, input logic [4:0] aAddr,
                               input logic [4:0] bAddr, input logic c);
    expT e;
    rst = r; we = w; wa = wAddr; wd = wData; ra = aAddr; rb = bAddr; clr = c;
    if (r) modelReset();
    e.a0 = expRead(0, aAddr);  e.b0 = expRead(0, bAddr);
    e.busy0 = (qSize(0) > 0);  e.done0 = doneM[0];
    e.a1 = expRead(1, aAddr);  e.b1 = expRead(1, bAddr);
    e.busy1 = (qSize(1) > 0);  e.done1 = doneM[1];
    expQ.push_back(e);
    @(posedge clock);
    if (!r) begin
      modelStep(0);
      modelStep(1);
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: read ports are always presenting, so every queued expectation is due this cycle.
  always @(negedge clock) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("readA_zb", rA0, e.a0);
      checkOutput("readB_zb", rB0, e.b0);
      checkOutput("busy_zb", {31'd0, busy0}, {31'd0, e.busy0});
      checkOutput("done_zb", {31'd0, done0}, {31'd0, e.done0});
      checkOutput("readA_plain", rA1, e.a1);
      checkOutput("readB_plain", rB1, e.b1);
      checkOutput("busy_plain", {31'd0, busy1}, {31'd0, e.busy1});
      checkOutput("done_plain", {31'd0, done1}, {31'd0, e.done1});
    end
  end

  task automatic fillAll();
    for (int i = 1; i < 32; i++)
      applyStimulus(0, 1, 5'(i), 32'(i + 100), 5'(i - 1), 5'($urandom_range(31)), 0);
  endtask

  task automatic sweepReads();
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 0);
  endtask

  initial begin
    logic r, w, c;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0; clr = 1'b0;
    modelReset();
    @(posedge clock);
    #1;

    applyStimulus(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0);
    applyStimulus(1, 0, 5'd0, 32'd0, 5'd9, 5'd31, 0);
    sweepReads();

    applyStimulus(0, 1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 0);
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd7, 5'd7, 0);
    applyStimulus(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0, 0);
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd0, 5'd7, 0);
    applyStimulus(0, 1, 5'd3, 32'h1, 5'd3, 5'd0, 0);
    applyStimulus(0, 1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 0);
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd3, 5'd3, 0);

    // Full clear with a same-cycle write to r5, a discarded write to r20, and a stray retrigger.
    fillAll();
    applyStimulus(0, 1, 5'd5, 32'h77, 5'd5, 5'd11, 1);
    for (int k = 0; k < 36; k++)
      applyStimulus(0, (k == 4), 5'd20, 32'h55, 5'(k), 5'd11, (k == 12));
    sweepReads();

    // Reset in the middle of a clear sequence.
    fillAll();
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd1, 5'd11, 1);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 5'd0, 32'd0, 5'(k), 5'd11, 0);
    applyStimulus(1, 0, 5'd0, 32'd0, 5'd11, 5'd31, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 5'd0, 32'd0, 5'(k + 10), 5'd31, 0);
    sweepReads();

    for (int n = 0; n < 500; n++) begin
      r = ($urandom_range(149) == 0);
      w = !r && $urandom_range(1);
      c = ($urandom_range(39) == 0);
      applyStimulus(r, w, 5'($urandom_range(31)), $urandom, 5'($urandom_range(31)),
                    5'($urandom_range(31)), c);
    end
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0);

    for (int t = 0; t < 4 && expQ.size() > 0; t++) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the 32x32 processor register file. It provides a width- and depth-configurable register array with two combinational read ports and one synchronous write port. It adds an optional hardwired-zero register 0, optional same-cycle write-to-read bypass, and a sequenced bulk-clear engine with a busy/done handshake. It sits in the decode stage and is driven by the control unit.

## Interface
- WIDTH, 32, data width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is an ordinary register
- BYPASS, 1, 1: a read of the register being written returns data_writeReg in the same cycle; 0: the read returns the old contents
- clock  in  1  single clock; all state updates on the rising edge
- ctrl_reset  in  1  asynchronous, active-high; zeroes all registers and the clear engine
- ctrl_writeEnable  in  1  write request
- ctrl_writeReg  in  ADDR_W  write address
- data_writeReg  in  WIDTH  write data
- ctrl_readRegA  in  ADDR_W  read address, port A
- ctrl_readRegB  in  ADDR_W  read address, port B
- data_readRegA  out  WIDTH  read data, port A (combinational)
- data_readRegB  out  WIDTH  read data, port B (combinational)
- ctrl_clear  in  1  bulk-clear request, sampled on the rising edge
- clear_busy  out  1  high while the clear sequence runs
- clear_done  out  1  one-cycle pulse after the last register is cleared

## Operation
- Write: at the rising edge, when ctrl_writeEnable=1 and state=IDLE, reg[ctrl_writeReg] <= data_writeReg.
  - When ZERO_REG=1, a write to address 0 is discarded.
  - When state=CLEAR, the write is discarded.
- Read: data_readRegX = reg[ctrl_readRegX], with no clock involved. The following overrides apply in priority order:
  - When ZERO_REG=1 and the address is 0, the output is 0.
  - When BYPASS=1, state=IDLE, ctrl_writeEnable=1, and ctrl_writeReg equals the read address, the output is data_writeReg.
- Ports A and B are fully independent. A and B may address the same register.
- Clear FSM has two states, IDLE and CLEAR, plus an index counter ptr of ADDR_W bits.
  - IDLE, with ctrl_clear=1 at the edge: go to CLEAR, ptr <= FIRST. FIRST = 1 when ZERO_REG=1, otherwise 0.
  - CLEAR: each edge does reg[ptr] <= 0 and ptr <= ptr+1.
  - CLEAR at the edge where ptr = DEPTH-1: go to IDLE, and clear_done <= 1 for the next cycle.
  - ctrl_clear while in CLEAR is ignored. It is not queued.
- A write and ctrl_clear in the same IDLE cycle: the write is performed, then the clear sequence zeroes that register later.
- Reads during CLEAR return current array contents. Registers already cleared read 0. Bypass is inactive during CLEAR.
- ptr wrap: the terminal transition happens at DEPTH-1, so ptr never wraps to FIRST within a sequence.

## Timing
- Reset (asynchronous, immediate): all registers 0, state=IDLE, ptr=0, clear_busy=0, clear_done=0.
  - Read outputs become 0 as soon as ctrl_reset asserts. This is combinational from the cleared array.
- Write latency: data is visible on a read port the cycle after the write edge. With BYPASS=1 it is also visible in the write cycle itself.
- clear_busy = (state==CLEAR). It rises the cycle after ctrl_clear is sampled. It stays high for N = DEPTH-FIRST cycles.
- clear_done is registered. It is high for exactly one cycle, the cycle immediately after clear_busy falls.
- The next clear can be accepted in the same cycle that clear_done is high.
- Reset mid-clear aborts the sequence. All registers read 0, clear_busy=0, and clear_done does not pulse.
- Critical path is read mux plus bypass compare. There is no pipelining.

## Test plan
- Reset/defaults, WIDTH=32, ADDR_W=5: assert ctrl_reset. Then read every address on A and B -> all 0, clear_busy=0, clear_done=0.
- Write/read and zero register:
  - Write 0xDEADBEEF to r7, then read A=7, B=7 -> both 0xDEADBEEF next cycle.
  - Write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0.
  - Same test with ZERO_REG=0 -> r0 reads 0x12345678.
- Bypass:
  - BYPASS=1: r3 holds 0x1, write 0xAAAA5555 to r3 and read A=3 in the same cycle -> A=0xAAAA5555 before the edge.
  - BYPASS=0: same stimulus -> A=0x1 before the edge, 0xAAAA5555 after.
- Clear sequence, ZERO_REG=1, DEPTH=32:
  - Fill r1..r31 with the value index+100, then pulse ctrl_clear -> clear_busy high for exactly 31 cycles, clear_done high for 1 cycle.
  - Every register reads 0 afterward.
  - Mid-sequence, at cycle 10 of busy, r1..r10 read 0 and r11 still reads 111.
- Writes during clear: write 0x55 to r20 while clear_busy=1 -> write discarded, r20 reads 0 after done. A write to r5 in the same cycle as the ctrl_clear request is later zeroed.
- Reset mid-clear and retrigger:
  - Assert ctrl_reset at busy cycle 5 -> busy drops immediately, no clear_done, all registers 0.
  - ctrl_clear pulsed during busy -> sequence length is still 31, with no second run.
